// File: rtl/flash_read_controller.sv
// SPI flash read controller: issues a 0x03 READ command with a 24-bit address
// and returns the next four flash bytes as one little-endian 32-bit word.
module flash_read_controller #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CSB_GAP = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDone,
        StGap
    } state_e;

    localparam logic [7:0]      DivLast = 8'(CLK_DIV - 1);
    localparam int unsigned     GapW    = (CSB_GAP > 1) ? $clog2(CSB_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(CSB_GAP - 1);

    state_e          state_q;
    logic [7:0]      div_cnt_q;
    logic [5:0]      bit_cnt_q;
    logic [30:0]     tx_q;
    logic [31:0]     rx_q;
    logic [GapW-1:0] gap_cnt_q;
    logic            ready_q;
    logic            csb_q;
    logic            sck_q;
    logic            mosi_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;

    // Transaction FSM; every SPI pin and response output is a register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            div_cnt_q   <= 8'd0;
            bit_cnt_q   <= 6'd0;
            tx_q        <= 31'd0;
            rx_q        <= 32'd0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b1;
            csb_q       <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        state_q   <= StCmd;
                        ready_q   <= 1'b0;
                        csb_q     <= 1'b0;
                        sck_q     <= 1'b0;
                        div_cnt_q <= 8'd0;
                        bit_cnt_q <= 6'd0;
                        // Stream is {0x03, addr}; its first bit (0) goes out now,
                        // the remaining 31 bits wait in tx_q.
                        tx_q      <= {7'h03, req_addr};
                        mosi_q    <= 1'b0;
                    end else begin
                        // Re-arm only after one settled IDLE cycle past GAP.
                        ready_q <= 1'b1;
                    end
                end
                StCmd, StAddr, StData: begin
                    if (div_cnt_q != DivLast) begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end else begin
                        div_cnt_q <= 8'd0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state_q == StData) begin
                                rx_q <= {rx_q[30:0], flash_miso};
                            end
                        end else begin
                            // End of bit: drop SCK and present the next MOSI bit.
                            sck_q     <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            tx_q      <= {tx_q[29:0], 1'b0};
                            mosi_q    <= (bit_cnt_q < 6'd31) ? tx_q[30] : 1'b0;
                            if (bit_cnt_q == 6'd7) begin
                                state_q <= StAddr;
                            end else if (bit_cnt_q == 6'd31) begin
                                state_q <= StData;
                            end else if (bit_cnt_q == 6'd63) begin
                                state_q     <= StDone;
                                csb_q       <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                // rx_q holds flash bytes in arrival order; first byte
                                // lands in the low lane.
                                rsp_data_q  <= {rx_q[7:0], rx_q[15:8],
                                                rx_q[23:16], rx_q[31:24]};
                            end
                        end
                    end
                end
                StDone: begin
                    state_q   <= StGap;
                    gap_cnt_q <= '0;
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = ready_q && (state_q == StIdle) && !wb_rst_i;
    assign busy       = (state_q != StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign flash_csb  = csb_q;
    assign flash_sck  = sck_q;
    assign flash_mosi = mosi_q;

endmodule
